// File: rtl/ysyx_220066_mem_arbiter.sv
// IFU/LSU arbiter in front of a single 64-bit memory bus: round-robin grant,
// request/accept/response handshake, store lane formatting and load extension.
module ysyx_220066_mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req,
    input  logic [63:0] ifu_addr,
    output logic        ifu_gnt,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_instr,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [63:0] lsu_addr,
    input  logic [2:0]  lsu_op,
    input  logic [63:0] lsu_wdata,
    output logic        lsu_gnt,
    output logic        lsu_rvalid,
    output logic [63:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [63:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wmask,
    output logic [63:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t      state_r;
    logic        last_lsu_r;
    logic        owner_lsu_r;
    logic        we_r;
    logic [2:0]  off_r;
    logic [2:0]  op_r;
    logic        mem_valid_r;
    logic [63:0] mem_addr_r;
    logic        mem_we_r;
    logic [7:0]  mem_wmask_r;
    logic [63:0] mem_wdata_r;
    logic        ifu_rvalid_r;
    logic [31:0] ifu_instr_r;
    logic        lsu_rvalid_r;
    logic [63:0] lsu_rdata_r;
    logic        lsu_err_r;

    logic        idle_s;
    logic        pick_lsu_s;
    logic        pick_ifu_s;
    logic        lsu_bad_s;

    function automatic logic lsu_illegal(input logic we, input logic [2:0] op, input logic [2:0] a);
        logic bad;
        bad = 1'b0;
        case (op[1:0])
            2'b00:   bad = 1'b0;
            2'b01:   bad = a[0];
            2'b10:   bad = |a[1:0];
            2'b11:   bad = op[2] | (|a);
            default: bad = 1'b1;
        endcase
        // Unsigned variants only make sense for loads.
        if (we && op[2]) begin
            bad = 1'b1;
        end else begin
            bad = bad;
        end
        return bad;
    endfunction

    function automatic logic [7:0] store_mask(input logic [2:0] op, input logic [2:0] a);
        logic [7:0] m;
        case (op[1:0])
            2'b00:   m = 8'h01 << a;
            2'b01:   m = 8'h03 << {a[2:1], 1'b0};
            2'b10:   m = a[2] ? 8'hF0 : 8'h0F;
            2'b11:   m = 8'hFF;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    function automatic logic [63:0] store_data(input logic [2:0] op, input logic [63:0] wd);
        logic [63:0] d;
        case (op[1:0])
            2'b00:   d = {8{wd[7:0]}};
            2'b01:   d = {4{wd[15:0]}};
            2'b10:   d = {2{wd[31:0]}};
            2'b11:   d = wd;
            default: d = 64'd0;
        endcase
        return d;
    endfunction

    function automatic logic [63:0] load_extend(input logic [2:0] op, input logic [2:0] a,
                                                input logic [63:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        logic [63:0] r;
        b = rd[{a, 3'b000} +: 8];
        h = rd[{a[2:1], 4'b0000} +: 16];
        w = a[2] ? rd[63:32] : rd[31:0];
        case (op)
            3'b000:  r = {{56{b[7]}}, b};
            3'b001:  r = {{48{h[15]}}, h};
            3'b010:  r = {{32{w[31]}}, w};
            3'b011:  r = rd;
            3'b100:  r = {56'd0, b};
            3'b101:  r = {48'd0, h};
            3'b110:  r = {32'd0, w};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        idle_s     = (state_r == IDLE) && rst;
        pick_lsu_s = idle_s && lsu_req && (!ifu_req || !last_lsu_r);
        pick_ifu_s = idle_s && ifu_req && !pick_lsu_s;
        lsu_bad_s  = lsu_illegal(lsu_we, lsu_op, lsu_addr[2:0]);
    end

    assign lsu_gnt    = pick_lsu_s;
    assign ifu_gnt    = pick_ifu_s;
    assign mem_valid  = mem_valid_r;
    assign mem_addr   = mem_addr_r;
    assign mem_we     = mem_we_r;
    assign mem_wmask  = mem_wmask_r;
    assign mem_wdata  = mem_wdata_r;
    assign ifu_rvalid = ifu_rvalid_r;
    assign ifu_instr  = ifu_instr_r;
    assign lsu_rvalid = lsu_rvalid_r;
    assign lsu_rdata  = lsu_rdata_r;
    assign lsu_err    = lsu_err_r;

    // Transaction FSM with registered bus and response outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            last_lsu_r   <= 1'b0;
            owner_lsu_r  <= 1'b0;
            we_r         <= 1'b0;
            off_r        <= 3'd0;
            op_r         <= 3'd0;
            mem_valid_r  <= 1'b0;
            mem_addr_r   <= 64'd0;
            mem_we_r     <= 1'b0;
            mem_wmask_r  <= 8'd0;
            mem_wdata_r  <= 64'd0;
            ifu_rvalid_r <= 1'b0;
            ifu_instr_r  <= 32'd0;
            lsu_rvalid_r <= 1'b0;
            lsu_rdata_r  <= 64'd0;
            lsu_err_r    <= 1'b0;
        end else begin
            ifu_rvalid_r <= 1'b0;
            ifu_instr_r  <= 32'd0;
            lsu_rvalid_r <= 1'b0;
            lsu_rdata_r  <= 64'd0;
            lsu_err_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_lsu_s) begin
                        owner_lsu_r <= 1'b1;
                        last_lsu_r  <= 1'b1;
                        we_r        <= lsu_we;
                        off_r       <= lsu_addr[2:0];
                        op_r        <= lsu_op;
                        if (lsu_bad_s) begin
                            state_r <= ERR;
                        end else begin
                            state_r     <= ISSUE;
                            mem_valid_r <= 1'b1;
                            mem_addr_r  <= {lsu_addr[63:3], 3'b000};
                            mem_we_r    <= lsu_we;
                            mem_wmask_r <= lsu_we ? store_mask(lsu_op, lsu_addr[2:0]) : 8'd0;
                            mem_wdata_r <= lsu_we ? store_data(lsu_op, lsu_wdata) : 64'd0;
                        end
                    end else if (pick_ifu_s) begin
                        owner_lsu_r <= 1'b0;
                        last_lsu_r  <= 1'b0;
                        we_r        <= 1'b0;
                        off_r       <= ifu_addr[2:0];
                        op_r        <= 3'b000;
                        state_r     <= ISSUE;
                        mem_valid_r <= 1'b1;
                        mem_addr_r  <= {ifu_addr[63:3], 3'b000};
                        mem_we_r    <= 1'b0;
                        mem_wmask_r <= 8'd0;
                        mem_wdata_r <= 64'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_valid_r <= 1'b0;
                        state_r     <= WAIT;
                    end else begin
                        state_r <= ISSUE;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        state_r <= IDLE;
                        if (owner_lsu_r) begin
                            lsu_rvalid_r <= 1'b1;
                            lsu_rdata_r  <= we_r ? 64'd0 : load_extend(op_r, off_r, mem_rdata);
                        end else begin
                            ifu_rvalid_r <= 1'b1;
                            ifu_instr_r  <= off_r[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                        end
                    end else begin
                        state_r <= WAIT;
                    end
                end
                ERR: begin
                    lsu_rvalid_r <= 1'b1;
                    lsu_err_r    <= 1'b1;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_220066_mem_arbiter.sv
// Directed bench for ysyx_220066_mem_arbiter; expected responses are queued at
// grant time and checked by a monitor when the arbiter returns them.
module tb_ysyx_220066_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req;
    logic [63:0] ifu_addr;
    logic        ifu_gnt;
    logic        ifu_rvalid;
    logic [31:0] ifu_instr;
    logic        lsu_req;
    logic        lsu_we;
    logic [63:0] lsu_addr;
    logic [2:0]  lsu_op;
    logic [63:0] lsu_wdata;
    logic        lsu_gnt;
    logic        lsu_rvalid;
    logic [63:0] lsu_rdata;
    logic        lsu_err;
    logic        mem_valid;
    logic        mem_ready;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_wdata;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    ysyx_220066_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
        .ifu_rvalid(ifu_rvalid), .ifu_instr(ifu_instr),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_op(lsu_op),
        .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
        .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lsu;
        logic        err;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: every rvalid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ifu_rvalid || lsu_rvalid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", {62'd0, lsu_rvalid, ifu_rvalid}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rv_owner", {62'd0, lsu_rvalid, ifu_rvalid}, e.lsu ? 64'd2 : 64'd1);
                if (e.lsu) begin
                    chk("lsu_rdata", lsu_rdata, e.data);
                    chk("lsu_err", {63'd0, lsu_err}, {63'd0, e.err});
                end else begin
                    chk("ifu_instr", {32'd0, ifu_instr}, e.data);
                end
                if (e.cyc >= 0) chk("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic lsu_txn(input string tag, input logic we, input logic [63:0] addr,
                           input logic [2:0] op, input logic [63:0] wd, input logic [63:0] rd,
                           input logic [63:0] exp_rd, input logic exp_err,
                           input logic [63:0] exp_wd, input logic [7:0] exp_mask);
        int n;
        lsu_req = 1'b1; lsu_we = we; lsu_addr = addr; lsu_op = op; lsu_wdata = wd;
        n = 0;
        #1;
        while (!lsu_gnt && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk({tag, "_gnt"}, {63'd0, lsu_gnt}, 64'd1);
        sb.push_back('{1'b1, exp_err, exp_rd, cyc + (exp_err ? 2 : 3)});
        @(negedge clk);
        lsu_req = 1'b0;
        #1;
        if (exp_err) begin
            chk({tag, "_no_valid"}, {63'd0, mem_valid}, 64'd0);
            @(negedge clk); #1;
            chk({tag, "_no_valid2"}, {63'd0, mem_valid}, 64'd0);
        end else begin
            chk({tag, "_mem_valid"}, {63'd0, mem_valid}, 64'd1);
            chk({tag, "_mem_addr"}, mem_addr, addr & ~64'h7);
            chk({tag, "_mem_we"}, {63'd0, mem_we}, {63'd0, we});
            chk({tag, "_wmask"}, {56'd0, mem_wmask}, {56'd0, exp_mask});
            if (we) chk({tag, "_wdata"}, mem_wdata, exp_wd);
            mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd;
            @(negedge clk);
            mem_rvalid = 1'b0;
        end
    endtask

    initial begin
        int n;
        rst = 1'b0;
        ifu_req = 1'b0; ifu_addr = 64'd0;
        lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = 64'd0; lsu_op = 3'd0; lsu_wdata = 64'd0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_lsu_rvalid", {63'd0, lsu_rvalid}, 64'd0);
        chk("rst_ifu_rvalid", {63'd0, ifu_rvalid}, 64'd0);
        chk("rst_lsu_rdata", lsu_rdata, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Both requesters held: LSU first after reset, then strict alternation.
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_0010; lsu_op = 3'b011;
        ifu_req = 1'b1; ifu_addr = 64'h8000_0004;
        for (int k = 0; k < 4; k++) begin
            logic exp_l;
            exp_l = (k % 2 == 0);
            #1;
            chk("alt_lsu_gnt", {63'd0, lsu_gnt}, {63'd0, exp_l});
            chk("alt_ifu_gnt", {63'd0, ifu_gnt}, {63'd0, !exp_l});
            sb.push_back('{exp_l, 1'b0, exp_l ? 64'h0123_4567_89AB_CDEF : 64'h0000_0000_DEAD_BEEF, cyc + 3});
            @(negedge clk); #1;
            chk("alt_mem_valid", {63'd0, mem_valid}, 64'd1);
            chk("alt_mem_addr", mem_addr, exp_l ? 64'h8000_0010 : 64'h8000_0000);
            mem_ready = 1'b1;
            @(negedge clk);
            mem_ready = 1'b0; mem_rvalid = 1'b1;
            mem_rdata = exp_l ? 64'h0123_4567_89AB_CDEF : 64'hDEAD_BEEF_0000_0013;
            @(negedge clk);
            mem_rvalid = 1'b0;
        end
        lsu_req = 1'b0; ifu_req = 1'b0;

        lsu_txn("lw",  1'b0, 64'h8000_0004, 3'b010, 64'd0, 64'h8000_0001_1234_5678,
                64'hFFFF_FFFF_8000_0001, 1'b0, 64'd0, 8'h00);
        lsu_txn("lwu", 1'b0, 64'h8000_0004, 3'b110, 64'd0, 64'h8000_0001_1234_5678,
                64'h0000_0000_8000_0001, 1'b0, 64'd0, 8'h00);
        lsu_txn("lh",  1'b0, 64'h8000_0006, 3'b001, 64'd0, 64'h8001_0000_0000_0000,
                64'hFFFF_FFFF_FFFF_8001, 1'b0, 64'd0, 8'h00);
        lsu_txn("lbu", 1'b0, 64'h8000_0005, 3'b100, 64'd0, 64'h0000_F000_0000_0000,
                64'h0000_0000_0000_00F0, 1'b0, 64'd0, 8'h00);
        lsu_txn("sb",  1'b1, 64'h8000_0003, 3'b000, 64'h1122_3344_5566_77AB, 64'hFFFF_FFFF_FFFF_FFFF,
                64'd0, 1'b0, 64'hABAB_ABAB_ABAB_ABAB, 8'h08);
        lsu_txn("sh",  1'b1, 64'h8000_000A, 3'b001, 64'h0000_0000_0000_BEEF, 64'd0,
                64'd0, 1'b0, 64'hBEEF_BEEF_BEEF_BEEF, 8'h0C);
        lsu_txn("sw",  1'b1, 64'h8000_0014, 3'b010, 64'h5555_5555_CAFE_BABE, 64'd0,
                64'd0, 1'b0, 64'hCAFE_BABE_CAFE_BABE, 8'hF0);
        lsu_txn("sd",  1'b1, 64'h8000_0018, 3'b011, 64'h0102_0304_0506_0708, 64'd0,
                64'd0, 1'b0, 64'h0102_0304_0506_0708, 8'hFF);
        lsu_txn("mis_lh",  1'b0, 64'h8000_0001, 3'b001, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 8'h00);
        lsu_txn("st_op4",  1'b1, 64'h8000_0000, 3'b100, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 8'h00);
        lsu_txn("op7",     1'b0, 64'h8000_0000, 3'b111, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 8'h00);
        lsu_txn("mis_lw",  1'b0, 64'h8000_0002, 3'b010, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 8'h00);

        // Stalled bus: fields hold, spurious response during ISSUE ignored.
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_0020; lsu_op = 3'b000;
        n = 0;
        #1;
        while (!lsu_gnt && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("stall_gnt", {63'd0, lsu_gnt}, 64'd1);
        sb.push_back('{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, -1});
        @(negedge clk);
        lsu_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_valid", {63'd0, mem_valid}, 64'd1);
            chk("stall_addr", mem_addr, 64'h8000_0020);
            chk("stall_no_rvalid", {63'd0, lsu_rvalid}, 64'd0);
            mem_rvalid = (k == 1);
            mem_rdata = 64'h0000_0000_0000_007F;
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        #1;
        chk("stall_valid_end", {63'd0, mem_valid}, 64'd1);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_0000_0080;
        @(negedge clk);
        mem_rvalid = 1'b0;

        // Reset while waiting for the response: the late response must vanish.
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 64'h8000_0000; lsu_op = 3'b010;
        n = 0;
        #1;
        while (!lsu_gnt && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("rstw_gnt", {63'd0, lsu_gnt}, 64'd1);
        @(negedge clk);
        lsu_req = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("rstw_mem_addr", mem_addr, 64'd0);
        chk("rstw_wmask", {56'd0, mem_wmask}, 64'd0);
        chk("rstw_lsu_rvalid", {63'd0, lsu_rvalid}, 64'd0);
        chk("rstw_lsu_err", {63'd0, lsu_err}, 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 64'h1234_5678_1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("rstw_late_rvalid", {63'd0, lsu_rvalid}, 64'd0);
        @(negedge clk);
        lsu_txn("post_rst", 1'b0, 64'h8000_0008, 3'b011, 64'd0, 64'hA5A5_5A5A_0F0F_F0F0,
                64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 64'd0, 8'h00);

        repeat (3) @(negedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
